// File: rtl/ibex_pkg.sv
// Shared constants, types and helpers for the register-file write arbiter.
package ibex_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned RegCountI = 32;
    localparam int unsigned RegCountE = 16;

    typedef enum logic [1:0] {
        WrSelNone,
        WrSelWb,
        WrSelFifo,
        WrSelBypass
    } wr_sel_e;

    // True when the address names a real, writable register (not x0, in range for RV32E).
    function automatic logic reg_writable(input logic [RegAddrW-1:0] addr, input logic rv32e);
        return (addr != '0) && !(rv32e && addr[RegAddrW-1]);
    endfunction

endpackage

// File: rtl/ibex_rf_write_fifo.sv
// LSU load-data write buffer: circular flop array with read/write pointers and occupancy.
module ibex_rf_write_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 37
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push, pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Single-port register-file write arbiter: WB first, buffered LSU data next, LSU bypass last,
// plus a per-register scoreboard of outstanding loads.
module ibex_rf_write_arbiter
    import ibex_pkg::*;
#(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned LsuFifoDepth = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              we_wb_i,
    input  logic [RegAddrW-1:0]               waddr_wb_i,
    input  logic [DataWidth-1:0]              wdata_wb_i,
    input  logic                              lsu_valid_i,
    output logic                              lsu_ready_o,
    input  logic [RegAddrW-1:0]               waddr_lsu_i,
    input  logic [DataWidth-1:0]              wdata_lsu_i,
    input  logic                              ld_issue_i,
    input  logic [RegAddrW-1:0]               ld_rd_i,
    input  logic [RegAddrW-1:0]               raddr_a_i,
    input  logic [RegAddrW-1:0]               raddr_b_i,
    output logic                              hazard_a_o,
    output logic                              hazard_b_o,
    output logic                              rf_we_o,
    output logic [RegAddrW-1:0]               rf_waddr_o,
    output logic [DataWidth-1:0]              rf_wdata_o,
    output logic [$clog2(LsuFifoDepth+1)-1:0] lsu_fifo_cnt_o
);

    localparam int unsigned NumRegs = RV32E ? RegCountE : RegCountI;
    localparam int unsigned IdxW    = $clog2(NumRegs);
    localparam int unsigned EntryW  = RegAddrW + DataWidth;
    localparam int unsigned CntW    = $clog2(LsuFifoDepth + 1);

    wr_sel_e              sel;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, head_vld;
    logic [EntryW-1:0]    fifo_rdata;
    logic [CntW-1:0]      fifo_cnt;
    logic [RegAddrW-1:0]  head_addr;
    logic [DataWidth-1:0] head_data;
    logic                 lsu_commit;
    logic [RegAddrW-1:0]  commit_addr;
    logic [NumRegs-1:0]   pending_q, pending_d;

    ibex_rf_write_fifo #(
        .Depth(LsuFifoDepth),
        .Width(EntryW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .wdata_i({waddr_lsu_i, wdata_lsu_i}),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .cnt_o  (fifo_cnt)
    );

    assign head_addr = fifo_rdata[EntryW-1 -: RegAddrW];
    assign head_data = fifo_rdata[DataWidth-1:0];

    // While in reset the buffer is treated as empty so nothing stale reaches the port.
    assign head_vld       = !fifo_empty && !rst_i;
    assign lsu_ready_o    = !fifo_full && !rst_i;
    assign lsu_fifo_cnt_o = rst_i ? '0 : fifo_cnt;

    always_comb begin
        sel         = WrSelNone;
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        lsu_commit  = 1'b0;
        commit_addr = head_addr;
        if (we_wb_i) begin
            sel = WrSelWb;
        end else if (head_vld) begin
            sel = WrSelFifo;
        end else if (lsu_valid_i && !rst_i) begin
            sel = WrSelBypass;
        end
        case (sel)
            WrSelWb: begin
                rf_waddr_o = waddr_wb_i;
                rf_wdata_o = wdata_wb_i;
                rf_we_o    = reg_writable(waddr_wb_i, RV32E);
            end
            WrSelFifo: begin
                rf_waddr_o = head_addr;
                rf_wdata_o = head_data;
                rf_we_o    = reg_writable(head_addr, RV32E);
                lsu_commit = 1'b1;
            end
            WrSelBypass: begin
                rf_waddr_o  = waddr_lsu_i;
                rf_wdata_o  = wdata_lsu_i;
                rf_we_o     = reg_writable(waddr_lsu_i, RV32E);
                lsu_commit  = 1'b1;
                commit_addr = waddr_lsu_i;
            end
            default: ;
        endcase
    end

    assign fifo_pop  = (sel == WrSelFifo);
    assign fifo_push = lsu_valid_i && lsu_ready_o && (sel != WrSelBypass);

    // Set is applied after clear so a same-cycle issue to the committing register wins.
    always_comb begin
        pending_d = pending_q;
        if (lsu_commit && reg_writable(commit_addr, RV32E)) begin
            pending_d[commit_addr[IdxW-1:0]] = 1'b0;
        end
        if (ld_issue_i && reg_writable(ld_rd_i, RV32E)) begin
            pending_d[ld_rd_i[IdxW-1:0]] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard_a_o = !rst_i && reg_writable(raddr_a_i, RV32E) && pending_q[raddr_a_i[IdxW-1:0]];
    assign hazard_b_o = !rst_i && reg_writable(raddr_b_i, RV32E) && pending_q[raddr_b_i[IdxW-1:0]];

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_ibex_rf_write_arbiter;

    localparam bit          RV32E = 1'b0;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_i;
    logic          we_wb_i;
    logic [4:0]    waddr_wb_i;
    logic [DW-1:0] wdata_wb_i;
    logic          lsu_valid_i;
    logic          lsu_ready_o;
    logic [4:0]    waddr_lsu_i;
    logic [DW-1:0] wdata_lsu_i;
    logic          ld_issue_i;
    logic [4:0]    ld_rd_i;
    logic [4:0]    raddr_a_i;
    logic [4:0]    raddr_b_i;
    logic          hazard_a_o;
    logic          hazard_b_o;
    logic          rf_we_o;
    logic [4:0]    rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic [CW-1:0] lsu_fifo_cnt_o;

    int checks = 0;
    int errors = 0;

    ibex_rf_write_arbiter #(
        .RV32E(RV32E),
        .DataWidth(DW),
        .LsuFifoDepth(DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .we_wb_i       (we_wb_i),
        .waddr_wb_i    (waddr_wb_i),
        .wdata_wb_i    (wdata_wb_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .waddr_lsu_i   (waddr_lsu_i),
        .wdata_lsu_i   (wdata_lsu_i),
        .ld_issue_i    (ld_issue_i),
        .ld_rd_i       (ld_rd_i),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .hazard_a_o    (hazard_a_o),
        .hazard_b_o    (hazard_b_o),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .lsu_fifo_cnt_o(lsu_fifo_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit writable(input logic [4:0] a);
        return (a != 5'd0) && !(RV32E && a[4]);
    endfunction

    // Reference model: buffer contents as a queue, outstanding loads as a bit per register.
    logic [36:0]   mq[$];
    logic [31:0]   pend = '0;
    int            occ;
    int            src;
    logic [4:0]    ea;
    logic [DW-1:0] ed;
    logic          exp_ready, exp_we, exp_ha, exp_hb;
    logic [CW-1:0] exp_cnt;

    initial begin : compare
        forever begin
            @(negedge clk);
            #2;
            occ       = mq.size();
            exp_ready = !rst_i && (occ < DEPTH);
            exp_cnt   = rst_i ? '0 : CW'(occ);
            src       = 0;
            ea        = '0;
            ed        = '0;
            if (we_wb_i) begin
                src = 1; ea = waddr_wb_i; ed = wdata_wb_i;
            end else if (!rst_i && occ > 0) begin
                src = 2; {ea, ed} = mq[0];
            end else if (!rst_i && lsu_valid_i) begin
                src = 3; ea = waddr_lsu_i; ed = wdata_lsu_i;
            end
            exp_we = (src != 0) && writable(ea);
            exp_ha = !rst_i && writable(raddr_a_i) && pend[raddr_a_i];
            exp_hb = !rst_i && writable(raddr_b_i) && pend[raddr_b_i];

            chk("m_we", 64'(rf_we_o), 64'(exp_we));
            if (exp_we) begin
                chk("m_waddr", 64'(rf_waddr_o), 64'(ea));
                chk("m_wdata", 64'(rf_wdata_o), 64'(ed));
            end
            chk("m_ready", 64'(lsu_ready_o), 64'(exp_ready));
            chk("m_cnt", 64'(lsu_fifo_cnt_o), 64'(exp_cnt));
            chk("m_haz_a", 64'(hazard_a_o), 64'(exp_ha));
            chk("m_haz_b", 64'(hazard_b_o), 64'(exp_hb));

            if (rst_i) begin
                mq.delete();
                pend = '0;
            end else begin
                if (src == 2 || src == 3) pend[ea] = 1'b0;
                if (src == 2) void'(mq.pop_front());
                if (lsu_valid_i && exp_ready && src != 3) mq.push_back({waddr_lsu_i, wdata_lsu_i});
                if (ld_issue_i && writable(ld_rd_i)) pend[ld_rd_i] = 1'b1;
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        rst_i = 1'b0; we_wb_i = 1'b0; waddr_wb_i = '0; wdata_wb_i = '0;
        lsu_valid_i = 1'b0; waddr_lsu_i = '0; wdata_lsu_i = '0;
        ld_issue_i = 1'b0; ld_rd_i = '0; raddr_a_i = '0; raddr_b_i = '0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [DW-1:0] d);
        we_wb_i = 1'b1; waddr_wb_i = a; wdata_wb_i = d;
    endtask

    task automatic lsu(input logic [4:0] a, input logic [DW-1:0] d);
        lsu_valid_i = 1'b1; waddr_lsu_i = a; wdata_lsu_i = d;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin : driver
        rst_i = 1'b1; we_wb_i = 1'b0; waddr_wb_i = '0; wdata_wb_i = '0;
        lsu_valid_i = 1'b0; waddr_lsu_i = '0; wdata_lsu_i = '0;
        ld_issue_i = 1'b0; ld_rd_i = '0; raddr_a_i = '0; raddr_b_i = '0;

        // Reset state, then ready in the first cycle out of reset.
        repeat (2) begin
            next_cycle(); rst_i = 1'b1; #3;
            chk("rst_cnt", 64'(lsu_fifo_cnt_o), 64'd0);
            chk("rst_ready", 64'(lsu_ready_o), 64'd0);
            chk("rst_we", 64'(rf_we_o), 64'd0);
        end
        next_cycle(); #3;
        chk("post_rst_ready", 64'(lsu_ready_o), 64'd1);

        // Bypass with zero latency, clearing the outstanding load on x5.
        next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd5;
        next_cycle(); raddr_a_i = 5'd5; lsu(5'd5, 32'hA5A5A5A5); #3;
        chk("byp_haz_before", 64'(hazard_a_o), 64'd1);
        chk("byp_we", 64'(rf_we_o), 64'd1);
        chk("byp_waddr", 64'(rf_waddr_o), 64'd5);
        chk("byp_wdata", 64'(rf_wdata_o), 64'hA5A5A5A5);
        chk("byp_cnt", 64'(lsu_fifo_cnt_o), 64'd0);
        next_cycle(); raddr_a_i = 5'd5; #3;
        chk("byp_haz_after", 64'(hazard_a_o), 64'd0);

        // WB / LSU collision: WB first, LSU one cycle later from the buffer.
        next_cycle(); wb(5'd3, 32'h11); lsu(5'd7, 32'h22); #3;
        chk("col_c0_addr", 64'(rf_waddr_o), 64'd3);
        chk("col_c0_data", 64'(rf_wdata_o), 64'h11);
        chk("col_c0_cnt", 64'(lsu_fifo_cnt_o), 64'd0);
        next_cycle(); #3;
        chk("col_c1_cnt", 64'(lsu_fifo_cnt_o), 64'd1);
        chk("col_c1_we", 64'(rf_we_o), 64'd1);
        chk("col_c1_addr", 64'(rf_waddr_o), 64'd7);
        chk("col_c1_data", 64'(rf_wdata_o), 64'h22);
        next_cycle(); #3;
        chk("col_c2_cnt", 64'(lsu_fifo_cnt_o), 64'd0);
        chk("col_c2_we", 64'(rf_we_o), 64'd0);

        // Backpressure: WB busy 4 cycles, buffer fills, then drains in order.
        next_cycle(); wb(5'd10, 32'h100); lsu(5'd20, 32'h200);
        next_cycle(); wb(5'd11, 32'h101); lsu(5'd21, 32'h201);
        next_cycle(); wb(5'd12, 32'h102); lsu(5'd22, 32'h202); #3;
        chk("bp_full_cnt", 64'(lsu_fifo_cnt_o), 64'd2);
        chk("bp_full_ready", 64'(lsu_ready_o), 64'd0);
        next_cycle(); wb(5'd13, 32'h103); lsu(5'd22, 32'h202); #3;
        chk("bp_wb_addr", 64'(rf_waddr_o), 64'd13);
        chk("bp_ready_c3", 64'(lsu_ready_o), 64'd0);
        next_cycle(); lsu(5'd22, 32'h202); #3;
        chk("bp_drain0", 64'(rf_waddr_o), 64'd20);
        chk("bp_drain0_d", 64'(rf_wdata_o), 64'h200);
        next_cycle(); lsu(5'd22, 32'h202); #3;
        chk("bp_drain1", 64'(rf_waddr_o), 64'd21);
        chk("bp_drain1_ready", 64'(lsu_ready_o), 64'd1);
        next_cycle(); #3;
        chk("bp_drain2", 64'(rf_waddr_o), 64'd22);
        chk("bp_drain2_cnt", 64'(lsu_fifo_cnt_o), 64'd1);
        next_cycle(); #3;
        chk("bp_empty", 64'(lsu_fifo_cnt_o), 64'd0);

        // Scoreboard window for x9, and x0 never pending.
        next_cycle(); raddr_a_i = 5'd9; ld_issue_i = 1'b1; ld_rd_i = 5'd9; #3;
        chk("sb_issue_cycle", 64'(hazard_a_o), 64'd0);
        next_cycle(); raddr_a_i = 5'd9; #3;
        chk("sb_pend1", 64'(hazard_a_o), 64'd1);
        next_cycle(); raddr_a_i = 5'd9; #3;
        chk("sb_pend2", 64'(hazard_a_o), 64'd1);
        next_cycle(); raddr_a_i = 5'd9; lsu(5'd9, 32'h99); #3;
        chk("sb_commit_cycle", 64'(hazard_a_o), 64'd1);
        next_cycle(); raddr_a_i = 5'd9; #3;
        chk("sb_cleared", 64'(hazard_a_o), 64'd0);
        next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd0;
        next_cycle(); raddr_a_i = 5'd0; #3;
        chk("sb_x0", 64'(hazard_a_o), 64'd0);

        // Same-cycle set and clear on x4: set wins.
        next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd4;
        next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd4; raddr_b_i = 5'd4; lsu(5'd4, 32'h44); #3;
        chk("sc_haz_b", 64'(hazard_b_o), 64'd1);
        chk("sc_we", 64'(rf_we_o), 64'd1);
        next_cycle(); raddr_b_i = 5'd4; #3;
        chk("sc_still_pend", 64'(hazard_b_o), 64'd1);
        next_cycle(); lsu(5'd4, 32'h45);
        next_cycle(); raddr_b_i = 5'd4; #3;
        chk("sc_final_clear", 64'(hazard_b_o), 64'd0);

        // x0 write is consumed without a register-file write.
        next_cycle(); lsu(5'd0, 32'hDEAD); #3;
        chk("x0_we", 64'(rf_we_o), 64'd0);

        // Reset mid-operation with a full buffer and pending loads.
        next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd12;
        next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd13; wb(5'd1, 32'h1); lsu(5'd12, 32'hC);
        next_cycle(); wb(5'd2, 32'h2); lsu(5'd13, 32'hD); raddr_a_i = 5'd12; #3;
        chk("pre_rst_haz", 64'(hazard_a_o), 64'd1);
        next_cycle(); rst_i = 1'b1; raddr_a_i = 5'd12; raddr_b_i = 5'd13; #3;
        chk("mrst_cnt", 64'(lsu_fifo_cnt_o), 64'd0);
        chk("mrst_haz_a", 64'(hazard_a_o), 64'd0);
        chk("mrst_haz_b", 64'(hazard_b_o), 64'd0);
        chk("mrst_we", 64'(rf_we_o), 64'd0);
        next_cycle(); rst_i = 1'b1; wb(5'd6, 32'h66); #3;
        chk("mrst_wb_we", 64'(rf_we_o), 64'd1);
        chk("mrst_wb_addr", 64'(rf_waddr_o), 64'd6);
        next_cycle(); raddr_a_i = 5'd12; #3;
        chk("after_rst_we", 64'(rf_we_o), 64'd0);
        chk("after_rst_cnt", 64'(lsu_fifo_cnt_o), 64'd0);
        chk("after_rst_ready", 64'(lsu_ready_o), 64'd1);
        chk("after_rst_haz", 64'(hazard_a_o), 64'd0);

        // Randomized traffic, alternating light and heavy WB phases.
        for (int i = 0; i < 4000; i++) begin
            next_cycle();
            rst_i       = ($urandom_range(0, 249) == 0);
            we_wb_i     = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            waddr_wb_i  = pick_addr();
            wdata_wb_i  = $urandom;
            lsu_valid_i = $urandom_range(0, 1) == 1;
            waddr_lsu_i = pick_addr();
            wdata_lsu_i = $urandom;
            ld_issue_i  = $urandom_range(0, 2) == 0;
            ld_rd_i     = pick_addr();
            raddr_a_i   = pick_addr();
            raddr_b_i   = pick_addr();
        end
        repeat (6) next_cycle();
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
